// File: rtl/ro_sequencer.sv
// -----------------------------------------------------------------------------
// ro_sequencer
//
// Sequences one ring-oscillator (RO) sampling run:
//   1. The selected ROs warm up.
//   2. The ROs run while the 64-bit RO buffer shift register refills.
//   3. The eight buffer bytes are read out over a valid/ready byte stream,
//      most significant byte (out_sel = 7) first.
// In continuous mode, the fill/readout phases repeat until abort.
//
// Ports
//   clk            single clock; all state changes on its rising edge
//   rst_n          asynchronous active-low reset
//   start          requests a run; only looked at while idle
//   abort          returns to idle on the next edge from any state
//   continuous     latched at start; 1 = repeat fill/readout until abort
//   ro_mask[1:0]   latched at start; bit0 -> ro_activate_1, bit1 -> ro_activate_2
//   ro_byte[7:0]   buffer byte selected by out_sel
//   data_ready     consumer accepts data_out
//   ro_activate_1  registered enable for RO 1
//   ro_activate_2  registered enable for RO 2
//   out_sel[2:0]   registered byte select into the RO buffer
//   data_out[7:0]  byte stream data
//   data_valid     byte stream valid
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse at the end of a non-continuous run
//   err            one-cycle pulse when start arrives with an empty mask
// -----------------------------------------------------------------------------
module ro_sequencer #(
    parameter int WARMUP_CYCLES = 16,
    parameter int FILL_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       continuous,
    input  logic [1:0] ro_mask,
    input  logic [7:0] ro_byte,
    input  logic       data_ready,
    output logic       ro_activate_1,
    output logic       ro_activate_2,
    output logic [2:0] out_sel,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Terminal counts: the counter runs 0..N-1, so a phase lasts exactly N cycles.
    localparam logic [7:0] WARMUP_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [7:0] FILL_LAST   = 8'(FILL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_SEL    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_VALID  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic [2:0] idx_r;
    logic [2:0] idx_s;
    logic       cont_r;
    logic       cont_s;

    logic       ro1_s;
    logic       ro2_s;
    logic [2:0] out_sel_s;
    logic [7:0] data_out_s;
    logic       data_valid_s;
    logic       busy_s;
    logic       done_s;
    logic       err_s;

    // State, counters and every output are registered here from their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            idx_r         <= 3'd0;
            cont_r        <= 1'b0;
            ro_activate_1 <= 1'b0;
            ro_activate_2 <= 1'b0;
            out_sel       <= 3'd0;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            idx_r         <= idx_s;
            cont_r        <= cont_s;
            ro_activate_1 <= ro1_s;
            ro_activate_2 <= ro2_s;
            out_sel       <= out_sel_s;
            data_out      <= data_out_s;
            data_valid    <= data_valid_s;
            busy          <= busy_s;
            done          <= done_s;
            err           <= err_s;
        end
    end

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        idx_s        = idx_r;
        cont_s       = cont_r;
        ro1_s        = ro_activate_1;
        ro2_s        = ro_activate_2;
        out_sel_s    = out_sel;
        data_out_s   = data_out;
        data_valid_s = data_valid;
        done_s       = 1'b0;
        err_s        = 1'b0;

        if (abort) begin
            // Abort also swallows a coincident start in IDLE, so no err pulse.
            state_s      = ST_IDLE;
            cnt_s        = 8'd0;
            idx_s        = 3'd0;
            ro1_s        = 1'b0;
            ro2_s        = 1'b0;
            out_sel_s    = 3'd0;
            data_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ro1_s        = 1'b0;
                    ro2_s        = 1'b0;
                    data_valid_s = 1'b0;
                    if (start) begin
                        if (ro_mask != 2'b00) begin
                            // The RO enable registers double as the latched mask.
                            state_s = ST_WARMUP;
                            cnt_s   = 8'd0;
                            idx_s   = 3'd0;
                            cont_s  = continuous;
                            ro1_s   = ro_mask[0];
                            ro2_s   = ro_mask[1];
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end

                ST_WARMUP: begin
                    if (cnt_r == WARMUP_LAST) begin
                        state_s = ST_FILL;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end

                ST_FILL: begin
                    if (cnt_r == FILL_LAST) begin
                        // Readout always starts at the top byte of the buffer.
                        state_s   = ST_SEL;
                        cnt_s     = 8'd0;
                        idx_s     = 3'd7;
                        out_sel_s = 3'd7;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end

                ST_SEL: begin
                    state_s = ST_SETTLE;
                end

                ST_SETTLE: begin
                    // The buffer output has had two cycles to follow out_sel.
                    state_s      = ST_VALID;
                    data_out_s   = ro_byte;
                    data_valid_s = 1'b1;
                end

                ST_VALID: begin
                    if (data_ready) begin
                        data_valid_s = 1'b0;
                        if (idx_r != 3'd0) begin
                            state_s   = ST_SEL;
                            idx_s     = idx_r - 3'd1;
                            out_sel_s = idx_r - 3'd1;
                        end else if (cont_r) begin
                            // ROs stay enabled while the buffer refills.
                            state_s = ST_FILL;
                            cnt_s   = 8'd0;
                        end else begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                            ro1_s   = 1'b0;
                            ro2_s   = 1'b0;
                        end
                    end else begin
                        state_s = ST_VALID;
                    end
                end

                ST_DONE: begin
                    state_s = ST_IDLE;
                    ro1_s   = 1'b0;
                    ro2_s   = 1'b0;
                end

                default: begin
                    state_s      = ST_IDLE;
                    cnt_s        = 8'd0;
                    idx_s        = 3'd0;
                    ro1_s        = 1'b0;
                    ro2_s        = 1'b0;
                    out_sel_s    = 3'd0;
                    data_valid_s = 1'b0;
                end
            endcase
        end

        busy_s = (state_s != ST_IDLE);
    end

endmodule

// File: tb/tb_ro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ro_sequencer
//
// Directed sequence of runs with randomised side inputs. The expected
// behaviour comes from the timeline arithmetic of a run:
//   - out_sel moves to 7 exactly WARMUP+FILL edges after start
//     (FILL edges after the last transfer in continuous mode).
//   - Each byte is valid two edges after its out_sel change.
//   - Each byte is held until an edge with data_ready high.
// ro_byte carries random junk except in the one cycle in which it must be
// captured, so a mistimed capture shows up as wrong data.
// -----------------------------------------------------------------------------
module tb_ro_sequencer;

    localparam int WARMUP = 16;
    localparam int FILL   = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       continuous;
    logic [1:0] ro_mask;
    logic [7:0] ro_byte;
    logic       data_ready;
    logic       ro_activate_1;
    logic       ro_activate_2;
    logic [2:0] out_sel;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic       err;

    int vectors;
    int miscompares;

    ro_sequencer #(
        .WARMUP_CYCLES(WARMUP),
        .FILL_CYCLES  (FILL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .continuous   (continuous),
        .ro_mask      (ro_mask),
        .ro_byte      (ro_byte),
        .data_ready   (data_ready),
        .ro_activate_1(ro_activate_1),
        .ro_activate_2(ro_activate_2),
        .out_sel      (out_sel),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs that must not influence a run in progress get random values.
    task automatic jiggle(input bit hold);
        start      = hold ? 1'b1 : 1'($urandom_range(0, 1));
        ro_mask    = 2'($urandom_range(0, 3));
        continuous = 1'($urandom_range(0, 1));
        data_ready = 1'($urandom_range(0, 1));
        ro_byte    = 8'($urandom);
    endtask

    task automatic do_abort();
        abort   = 1'b1;
        start   = 1'b1;
        ro_mask = 2'b11;
        step();
        chk("abort_busy",  32'(busy),          32'd0);
        chk("abort_ro1",   32'(ro_activate_1), 32'd0);
        chk("abort_ro2",   32'(ro_activate_2), 32'd0);
        chk("abort_valid", 32'(data_valid),    32'd0);
        chk("abort_sel",   32'(out_sel),       32'd0);
        chk("abort_done",  32'(done),          32'd0);
        step();
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_err",  32'(err),  32'd0);
        abort = 1'b0;
        start = 1'b0;
        step();
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_done", 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_sel",   32'(out_sel),       32'd0);
        chk("rst_data",  32'(data_out),      32'd0);
        chk("rst_valid", 32'(data_valid),    32'd0);
        chk("rst_ro1",   32'(ro_activate_1), 32'd0);
        chk("rst_ro2",   32'(ro_activate_2), 32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_err",   32'(err),           32'd0);
        start = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("rst_idle_busy", 32'(busy), 32'd0);
    endtask

    // One run. intr_mode: 0 none, 1 abort, 2 reset, applied while byte
    // intr_byte of fill round intr_round is valid.
    task automatic run(input logic [1:0] mask, input bit cont, input int rounds,
                       input bit rand_stall, input int stall_byte, input int stall_len,
                       input bit hold, input int intr_mode, input int intr_round,
                       input int intr_byte);
        logic [7:0] exp_byte;
        logic [2:0] sel;
        int         nstall;
        int         nfill;
        abort      = 1'b0;
        start      = 1'b1;
        ro_mask    = mask;
        continuous = cont;
        step();
        chk("start_busy",  32'(busy),          32'd1);
        chk("start_ro1",   32'(ro_activate_1), 32'(mask[0]));
        chk("start_ro2",   32'(ro_activate_2), 32'(mask[1]));
        chk("start_err",   32'(err),           32'd0);
        chk("start_valid", 32'(data_valid),    32'd0);
        for (int r = 0; r < rounds; r++) begin
            nfill = (r == 0) ? (WARMUP + FILL - 1) : (FILL - 1);
            for (int i = 0; i < nfill; i++) begin
                jiggle(hold);
                step();
                chk("fill_sel",   32'(out_sel),       32'd0);
                chk("fill_valid", 32'(data_valid),    32'd0);
                chk("fill_ro1",   32'(ro_activate_1), 32'(mask[0]));
                chk("fill_ro2",   32'(ro_activate_2), 32'(mask[1]));
                chk("fill_busy",  32'(busy),          32'd1);
                chk("fill_err",   32'(err),           32'd0);
            end
            jiggle(hold);
            step();
            for (int k = 0; k < 8; k++) begin
                sel = 3'(7 - k);
                chk("sel_out",   32'(out_sel),       32'(sel));
                chk("sel_valid", 32'(data_valid),    32'd0);
                chk("sel_ro1",   32'(ro_activate_1), 32'(mask[0]));
                chk("sel_ro2",   32'(ro_activate_2), 32'(mask[1]));
                jiggle(hold);
                step();
                chk("settle_sel",   32'(out_sel),    32'(sel));
                chk("settle_valid", 32'(data_valid), 32'd0);
                jiggle(hold);
                exp_byte = 8'($urandom);
                ro_byte  = exp_byte;
                step();
                chk("byte_valid", 32'(data_valid),    32'd1);
                chk("byte_data",  32'(data_out),      32'(exp_byte));
                chk("byte_sel",   32'(out_sel),       32'(sel));
                chk("byte_ro1",   32'(ro_activate_1), 32'(mask[0]));
                chk("byte_ro2",   32'(ro_activate_2), 32'(mask[1]));
                if (intr_mode == 1 && r == intr_round && k == intr_byte) begin
                    do_abort();
                    return;
                end
                if (intr_mode == 2 && r == intr_round && k == intr_byte) begin
                    do_reset();
                    return;
                end
                nstall = (k == stall_byte) ? stall_len
                       : (rand_stall ? int'($urandom_range(0, 3)) : 0);
                for (int j = 0; j < nstall; j++) begin
                    jiggle(hold);
                    data_ready = 1'b0;
                    step();
                    chk("hold_valid", 32'(data_valid), 32'd1);
                    chk("hold_data",  32'(data_out),   32'(exp_byte));
                    chk("hold_sel",   32'(out_sel),    32'(sel));
                end
                jiggle(hold);
                data_ready = 1'b1;
                step();
                chk("acc_valid", 32'(data_valid), 32'd0);
            end
            if (!cont) begin
                chk("done_pulse", 32'(done),          32'd1);
                chk("done_ro1",   32'(ro_activate_1), 32'd0);
                chk("done_ro2",   32'(ro_activate_2), 32'd0);
                chk("done_busy",  32'(busy),          32'd1);
                chk("done_valid", 32'(data_valid),    32'd0);
                start = 1'b0;
                step();
                chk("idle_done", 32'(done),          32'd0);
                chk("idle_busy", 32'(busy),          32'd0);
                chk("idle_ro1",  32'(ro_activate_1), 32'd0);
                step();
                chk("idle2_busy", 32'(busy), 32'd0);
                chk("idle2_done", 32'(done), 32'd0);
                return;
            end
            chk("cont_done", 32'(done),          32'd0);
            chk("cont_sel",  32'(out_sel),       32'd0);
            chk("cont_ro1",  32'(ro_activate_1), 32'(mask[0]));
            chk("cont_ro2",  32'(ro_activate_2), 32'(mask[1]));
            chk("cont_busy", 32'(busy),          32'd1);
        end
        do_abort();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        continuous  = 1'b0;
        ro_mask     = 2'b00;
        ro_byte     = 8'h00;
        data_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel",   32'(out_sel),       32'd0);
        chk("reset_data",  32'(data_out),      32'd0);
        chk("reset_valid", 32'(data_valid),    32'd0);
        chk("reset_ro1",   32'(ro_activate_1), 32'd0);
        chk("reset_ro2",   32'(ro_activate_2), 32'd0);
        chk("reset_busy",  32'(busy),          32'd0);
        chk("reset_done",  32'(done),          32'd0);
        chk("reset_err",   32'(err),           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 32'(busy), 32'd0);

        // Empty mask: error pulse only.
        start   = 1'b1;
        ro_mask = 2'b00;
        step();
        chk("mask0_err",  32'(err),           32'd1);
        chk("mask0_busy", 32'(busy),          32'd0);
        chk("mask0_ro1",  32'(ro_activate_1), 32'd0);
        chk("mask0_ro2",  32'(ro_activate_2), 32'd0);
        start = 1'b0;
        step();
        chk("mask0_err_end", 32'(err),  32'd0);
        chk("mask0_busy2",   32'(busy), 32'd0);

        // Plain single run, consumer always ready.
        run(2'b11, 1'b0, 1, 1'b0, -1, 0, 1'b0, 0, 0, 0);
        // Ten cycles of backpressure on the byte at out_sel 4.
        run(2'b11, 1'b0, 1, 1'b0, 3, 10, 1'b0, 0, 0, 0);
        // Continuous run, RO 1 only, aborted in the second readout.
        run(2'b01, 1'b1, 3, 1'b1, -1, 0, 1'b0, 1, 1, 2);
        // Reset while the byte at out_sel 5 is valid, then a fresh run.
        run(2'b10, 1'b0, 1, 1'b1, -1, 0, 1'b0, 2, 0, 2);
        run(2'b01, 1'b0, 1, 1'b1, -1, 0, 1'b0, 0, 0, 0);
        // start held high for the whole run.
        run(2'b11, 1'b0, 1, 1'b1, -1, 0, 1'b1, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            run(2'($urandom_range(1, 3)), 1'b0, 1, 1'b1, -1, 0, 1'b0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ro_sequencer.md
RO_SEQUENCER -- requirements
Module: ro_sequencer

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 16, meaning cycles ROs run before fill counting (legal 1..255).
REQ-002 SHALL have parameter FILL_CYCLES, default 64, meaning cycles counted to refill the 64-bit buffer shift register (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a sampling run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate any run; highest priority.
REQ-007 SHALL have port continuous  input  1  latched at start; 1 = repeat fill/readout until abort.
REQ-008 SHALL have port ro_mask  input  2  latched at start; bit0 enables ro_activate_1, bit1 enables ro_activate_2.
REQ-009 SHALL have port ro_byte  input  8  registered byte from the RO buffer, selected by out_sel.
REQ-010 SHALL have port data_ready  input  1  consumer accepts data_out.
REQ-011 SHALL have ports ro_activate_1, ro_activate_2  output  1 each  registered RO enables.
REQ-012 SHALL have port out_sel  output  3  registered byte select to the RO buffer.
REQ-013 SHALL have ports data_out  output  8  and data_valid  output  1  valid/ready byte stream.
REQ-014 SHALL have ports busy  output  1 (state != IDLE), done  output  1 (one-cycle pulse), err  output  1 (one-cycle pulse).

Function
REQ-015 SHALL implement states IDLE, WARMUP, FILL, SEL, SETTLE, VALID, DONE.
REQ-016 IDLE: start=1 with ro_mask!=00 SHALL go to WARMUP, latch mask/continuous, clear counter, and set ro_activate_x = mask bit x on that edge.
REQ-017 IDLE: start=1 with ro_mask==00 SHALL stay IDLE and pulse err for one cycle.
REQ-018 WARMUP SHALL last exactly WARMUP_CYCLES cycles, then go to FILL with counter cleared.
REQ-019 FILL SHALL last exactly FILL_CYCLES cycles, then go to SEL with idx=7.
REQ-020 SEL SHALL drive out_sel=idx (registered, changing on SEL entry) for one cycle, then go to SETTLE for one cycle.
REQ-021 On SETTLE exit, data_out SHALL load ro_byte and data_valid SHALL rise (state VALID); the first byte therefore appears 2 cycles after out_sel changes.
REQ-022 VALID: data_out/data_valid SHALL be held stable until an edge with data_ready=1; that edge completes the transfer.
REQ-023 On transfer with idx>0: data_valid SHALL drop, idx decrements, go to SEL (minimum 3 cycles between bytes).
REQ-024 On transfer with idx==0: continuous=1 SHALL go to FILL (ROs stay active); continuous=0 SHALL go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, both ro_activate low, then go to IDLE.
REQ-026 ro_activate outputs SHALL stay at the latched mask from WARMUP through VALID; low in IDLE/DONE.
REQ-027 Byte order per run SHALL be out_sel 7,6,...,0 (8 bytes).
REQ-028 abort=1 in any state SHALL go to IDLE on the next edge: ROs low, data_valid low, out_sel=0, no done pulse; abort with start in IDLE keeps IDLE, no err.
REQ-029 start while busy SHALL be ignored; mask/continuous changes mid-run SHALL be ignored.
REQ-030 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, counter=0, idx=0, out_sel=0, data_out=0x00, data_valid=0, ro_activate_1=0, ro_activate_2=0, busy=0, done=0, err=0.
REQ-032 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Verification
REQ-033 Single run, mask=11, continuous=0, data_ready=1, defaults -> both ROs high 16+64+8x3 cycles; out_sel 7..0; 8 valid pulses, data_out equals ro_byte 2 cycles after each out_sel change; done pulse; ROs low.
REQ-034 Backpressure: data_ready low 10 cycles on byte 3 -> data_out/data_valid held constant 10 cycles, out_sel stays 4, no byte lost or duplicated.
REQ-035 mask=00 start -> err pulse 1 cycle, busy stays 0, ROs stay 0.
REQ-036 continuous=1, mask=01 -> after byte out_sel=0 transfer, FILL 64 cycles, out_sel restarts at 7; only ro_activate_1 high; abort -> IDLE next edge, no done.
REQ-037 rst_n low during VALID (idx=5) -> all outputs reset values immediately; start after release begins a fresh WARMUP.
REQ-038 start held high through entire run -> exactly one run per start in IDLE; second start pulse during FILL ignored.
